// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port round-robin front end for the shared 64-bit
// barrel shifter. Prepares RV64 W-form operands, shifts, sign-extends
// W results and returns them through a one-entry registered output stage.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_data,
    input  logic [5:0]  req0_shamt,
    input  logic [1:0]  req0_type,
    input  logic        req0_word,
    input  logic [3:0]  req0_tag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_data,
    input  logic [5:0]  req1_shamt,
    input  logic [1:0]  req1_type,
    input  logic        req1_word,
    input  logic [3:0]  req1_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_tag,
    output logic        out_src
);

    // Registered state
    logic        ptr_q;
    logic        out_valid_q;
    logic [63:0] out_data_q;
    logic [3:0]  out_tag_q;
    logic        out_src_q;

    // Combinational arbitration / datapath signals
    logic        any_valid_s;
    logic        grant_port_s;
    logic        can_accept_s;
    logic        accept_s;
    logic [63:0] sel_data_s;
    logic [5:0]  sel_shamt_s;
    logic [1:0]  sel_type_s;
    logic        sel_word_s;
    logic [3:0]  sel_tag_s;
    logic [63:0] shift_in_s;
    logic [5:0]  shift_num_s;
    logic [63:0] shift_out_s;
    logic [63:0] result_d;

    // Shared barrel shifter: 00/01 left, 10 logical right, 11 arithmetic right.
    function automatic logic [63:0] barrel_shift(input logic [63:0] val,
                                                 input logic [5:0]  amt,
                                                 input logic [1:0]  typ);
        logic [63:0] res;
        case (typ)
            2'b10:   res = val >> amt;
            2'b11:   res = $signed(val) >>> amt;
            default: res = val << amt;
        endcase
        return res;
    endfunction

    // Round-robin grant and ready generation; ready never looks at payload.
    always_comb begin
        any_valid_s  = req0_valid | req1_valid;
        can_accept_s = !out_valid_q || out_ready;
        if (req0_valid && req1_valid) begin
            grant_port_s = ptr_q;
        end else if (req1_valid) begin
            grant_port_s = 1'b1;
        end else begin
            grant_port_s = 1'b0;
        end
        accept_s   = any_valid_s && can_accept_s && !rst;
        req0_ready = accept_s && !grant_port_s;
        req1_ready = accept_s && grant_port_s;
    end

    // Select the granted request's payload.
    always_comb begin
        if (grant_port_s) begin
            sel_data_s  = req1_data;
            sel_shamt_s = req1_shamt;
            sel_type_s  = req1_type;
            sel_word_s  = req1_word;
            sel_tag_s   = req1_tag;
        end else begin
            sel_data_s  = req0_data;
            sel_shamt_s = req0_shamt;
            sel_type_s  = req0_type;
            sel_word_s  = req0_word;
            sel_tag_s   = req0_tag;
        end
    end

    // W-form operand preparation: right shifts see only the low word,
    // extended according to the shift kind; shamt[5] is dropped.
    always_comb begin
        if (sel_word_s) begin
            case (sel_type_s)
                2'b11:   shift_in_s = {{32{sel_data_s[31]}}, sel_data_s[31:0]};
                2'b10:   shift_in_s = {32'h0000_0000, sel_data_s[31:0]};
                default: shift_in_s = sel_data_s;
            endcase
            shift_num_s = {1'b0, sel_shamt_s[4:0]};
        end else begin
            shift_in_s  = sel_data_s;
            shift_num_s = sel_shamt_s;
        end
    end

    // Shift, then sign-extend the low word for W forms.
    always_comb begin
        shift_out_s = barrel_shift(shift_in_s, shift_num_s, sel_type_s);
        if (sel_word_s) begin
            result_d = {{32{shift_out_s[31]}}, shift_out_s[31:0]};
        end else begin
            result_d = shift_out_s;
        end
    end

    // Output register and round-robin pointer; reset discards any same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 64'h0;
            out_tag_q   <= 4'h0;
            out_src_q   <= 1'b0;
        end else if (accept_s) begin
            ptr_q       <= ~grant_port_s;
            out_valid_q <= 1'b1;
            out_data_q  <= result_d;
            out_tag_q   <= sel_tag_s;
            out_src_q   <= grant_port_s;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed-vector bench for shift_arbiter with
// hand-computed expected results.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_data, req1_data;
    logic [5:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_type, req1_type;
    logic        req0_word, req1_word;
    logic [3:0]  req0_tag, req1_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;
    logic        out_src;

    int checks = 0;
    int errors = 0;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_type(req0_type), .req0_word(req0_word),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_type(req1_type), .req1_word(req1_word),
        .req1_tag(req1_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [63:0] d, input logic [5:0] s,
                        input logic [1:0] t, input logic w, input logic [3:0] g);
        req0_valid = v; req0_data = d; req0_shamt = s; req0_type = t; req0_word = w; req0_tag = g;
    endtask

    task automatic set1(input logic v, input logic [63:0] d, input logic [5:0] s,
                        input logic [1:0] t, input logic w, input logic [3:0] g);
        req1_valid = v; req1_data = d; req1_shamt = s; req1_type = t; req1_word = w; req1_tag = g;
    endtask

    // Single request on one port with the other idle; checks acceptance and result.
    task automatic single(input string name, input logic port, input logic [63:0] d,
                          input logic [5:0] s, input logic [1:0] t, input logic w,
                          input logic [3:0] g, input logic [63:0] exp);
        if (port) set1(1'b1, d, s, t, w, g);
        else      set0(1'b1, d, s, t, w, g);
        #1;
        check({name, "_ready"}, port ? req1_ready : req0_ready, 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({name, "_valid"}, out_valid, 64'd1);
        check({name, "_data"},  out_data,  exp);
        check({name, "_tag"},   out_tag,   {60'd0, g});
        check({name, "_src"},   out_src,   {63'd0, port});
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        set0(1'b1, 64'h1, 6'd1, 2'b00, 1'b0, 4'h7);
        set1(1'b1, 64'h1, 6'd1, 2'b00, 1'b0, 4'h8);
        tick();
        check("rst_ready0", req0_ready, 64'd0);
        check("rst_ready1", req1_ready, 64'd0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("idle_valid", out_valid, 64'd0);
        check("idle_data",  out_data,  64'd0);
        check("idle_tag",   out_tag,   64'd0);
        check("idle_src",   out_src,   64'd0);

        // Basic and W-form shifts
        single("sll63",   1'b0, 64'h1, 6'd63, 2'b00, 1'b0, 4'h5, 64'h8000_0000_0000_0000);
        single("sllw31",  1'b0, 64'h1, 6'd31, 2'b00, 1'b1, 4'h1, 64'hFFFF_FFFF_8000_0000);
        single("sraw4",   1'b1, 64'h0000_0000_8000_0000, 6'd4, 2'b11, 1'b1, 4'h2, 64'hFFFF_FFFF_F800_0000);
        single("srlw33",  1'b0, 64'hFFFF_FFFF_8000_0000, 6'h21, 2'b10, 1'b1, 4'h3, 64'h0000_0000_4000_0000);
        single("sraw_pos",1'b1, 64'h0000_0000_7FFF_FFF0, 6'd4, 2'b11, 1'b1, 4'h4, 64'h0000_0000_07FF_FFFF);
        single("sllw_hi", 1'b0, 64'hFFFF_FFFF_0000_0001, 6'd1, 2'b01, 1'b1, 4'h6, 64'h2);
        single("sra63",   1'b1, 64'h8000_0000_0000_0000, 6'd63, 2'b11, 1'b0, 4'h9, 64'hFFFF_FFFF_FFFF_FFFF);
        single("srl63",   1'b0, 64'h8000_0000_0000_0000, 6'd63, 2'b10, 1'b0, 4'hA, 64'h1);
        single("sll01",   1'b1, 64'h3, 6'd4, 2'b01, 1'b0, 4'hB, 64'h30);

        // Arbitration from a fresh reset: strict alternation starting at port 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1'b1, 64'h1, 6'd1, 2'b00, 1'b0, 4'hA);
        set1(1'b1, 64'h100, 6'd8, 2'b10, 1'b0, 4'hB);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_ready1", req1_ready, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            check("rr_src",  out_src,  (i % 2 == 0) ? 64'd0 : 64'd1);
            check("rr_data", out_data, (i % 2 == 0) ? 64'h2 : 64'h1);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("solo1_src",   out_src,   64'd1);
            check("solo1_valid", out_valid, 64'd1);
        end

        // Backpressure: port 0 wins (ptr=0), then stall three cycles
        set0(1'b1, 64'h1234, 6'd4, 2'b00, 1'b0, 4'h3);
        set1(1'b1, 64'hF0, 6'd4, 2'b10, 1'b0, 4'h9);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready0", req0_ready, 64'd0);
            check("stall_ready1", req1_ready, 64'd0);
            tick();
            check("stall_valid", out_valid, 64'd1);
            check("stall_data",  out_data,  64'h12340);
            check("stall_tag",   out_tag,   64'h3);
        end
        out_ready = 1'b1;
        #1;
        check("drain_ready1", req1_ready, 64'd1);
        check("drain_ready0", req0_ready, 64'd0);
        tick();
        check("drain_valid", out_valid, 64'd1);
        check("drain_src",   out_src,   64'd1);
        check("drain_data",  out_data,  64'hF);
        check("drain_tag",   out_tag,   64'h9);

        // Reset mid-stream: port 0 accepted (ptr -> 1), then reset with both valid
        tick();
        check("pre_rst_src",   out_src,   64'd0);
        check("pre_rst_valid", out_valid, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready0", req0_ready, 64'd0);
        check("mid_rst_ready1", req1_ready, 64'd0);
        tick();
        check("post_rst_valid", out_valid, 64'd0);
        check("post_rst_data",  out_data,  64'd0);
        check("post_rst_tag",   out_tag,   64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready0", req0_ready, 64'd1);
        check("post_rst_ready1", req1_ready, 64'd0);
        tick();
        check("post_rst_src", out_src, 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-port front end for the shared 64-bit barrel_shifter in the RV64 execute stage. The block arbitrates between two shift requesters (port 0: integer ALU issue, port 1: secondary pipe/AMO/CSR path) with a round-robin pointer. It prepares operands for RV64 W-form shifts and drives a single barrel_shifter instance. It returns results through a one-entry registered output stage with valid/ready backpressure.

## Interface
- No parameters; all widths fixed (XLEN 64, tag 4).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle when valid && ready
- reqN_data  in  64  operand (N = 0, 1)
- reqN_shamt  in  6  shift amount
- reqN_type  in  2  00/01 left, 10 logical right, 11 arithmetic right
- reqN_word  in  1  1 = W-form (SLLW/SRLW/SRAW)
- reqN_tag  in  4  opaque tag, returned with result
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_data  out  64  shift result
- out_tag  out  4  tag of the accepted request
- out_src  out  1  port that issued the result

## Operation
- can_accept = !out_valid || out_ready.
- Arbitration (combinational):
  - If only one port is valid, that port is granted.
  - If both are valid, the port equal to `ptr` is granted.
  - reqN_ready = grant[N] && can_accept && !rst.
  - The ungranted port sees ready = 0.
- Pointer update: on every accept, ptr <= ~granted_port. With no accept, ptr holds.
- Operand prep for the granted request:
  - word = 0: shifter input = data; shiftnum = shamt[5:0].
  - word = 1, type 11: input = sign-extend of data[31:0] from bit 31.
  - word = 1, type 10: input = {32'b0, data[31:0]}.
  - word = 1, type 0x: input = data.
  - word = 1, any type: shiftnum = {1'b0, shamt[4:0]}. shamt[5] is ignored.
- Result post-processing:
  - word = 1: result = sign-extend of shifter_out[31:0].
  - word = 0: result = shifter_out unchanged.
- Output register:
  - On accept: out_valid <= 1; out_data, out_tag and out_src are loaded.
  - On drain with no accept: out_valid <= 0. Data fields hold their last value.
  - Drain and accept in the same cycle: the new result overwrites the register and out_valid stays 1.
- Stall (out_valid && !out_ready): both readies are 0. The output fields are stable, and ptr does not move.
- Reset values: out_valid = 0, out_data = 0, out_tag = 0, out_src = 0, ptr = 0. Readies are forced to 0 while rst = 1.
- A request accepted in the same cycle that rst is asserted is discarded. Reset dominates.

## Timing
- Latency: accept in cycle T -> out_valid = 1 with the result in cycle T+1.
- Throughput: 1 result per cycle under continuous out_ready = 1.
- Handshake rules:
  - Ready depends only on the valids, ptr, out_valid and out_ready. It does not depend on data, type or shamt.
  - Requesters must hold valid and payload stable until accepted.
- Fairness: under continuous dual valid with out_ready = 1, grants strictly alternate 0,1,0,1…, starting from ptr.
- Critical path: operand mux -> 6-level shifter -> W sign-extend -> output register. This must close in a single cycle.

## Test plan
- **Reset / basic left shift.** Hold rst for 2 cycles, then release with no requests. out_valid = 0 and all outputs read 0. Then req0: data = 0x1, shamt = 63, type = 00, word = 0, tag = 5. Next cycle: out_data = 0x8000000000000000, out_tag = 5, out_src = 0.
- **W forms.**
  - SLLW: data = 0x1, shamt = 31 -> 0xFFFFFFFF80000000.
  - SRAW: data = 0x0000000080000000, shamt = 4 -> 0xFFFFFFFFF8000000.
  - SRLW: data = 0xFFFFFFFF80000000, shamt = 0x21 -> 0x0000000040000000 (shamt masked to 1).
- **Arbitration.** Both ports valid continuously from reset, with out_ready = 1. out_src sequence is 0,1,0,1. When only port 1 is valid for 3 cycles, it gets 3 consecutive grants.
- **Backpressure.**
  - Set out_ready = 0 for 3 cycles with both ports valid. Both readies stay 0, out_data and out_tag are stable, and ptr is unchanged.
  - Raise out_ready. The held result drains and the next accept happens in the same cycle.
- **Arithmetic right, 64-bit.** data = 0x8000000000000000, shamt = 63: type 11 -> 0xFFFFFFFFFFFFFFFF; type 10 -> 0x1.
- **Reset mid-stream.** Assert rst while out_valid = 1 and both ports are valid. Next cycle: out_valid = 0, ptr = 0, no stale result is emitted, and readies are 0 during reset.
